// File: rtl/rpn_if.sv
// rpn_if: token handshake and downstream stack bus for the RPN engine.
interface rpn_if #(parameter int BANDWIDTH = 4) ();
  logic                 tok_valid;
  logic                 tok_is_op;
  logic [BANDWIDTH-1:0] tok_data;
  logic                 tok_ready;
  logic                 stk_push;
  logic                 stk_pop;
  logic [BANDWIDTH-1:0] stk_data_in;
  logic [BANDWIDTH-1:0] stk_data_out;
  logic                 stk_full;
  logic                 stk_empty;
  modport master (
    output tok_valid, tok_is_op, tok_data, stk_data_out, stk_full, stk_empty,
    input  tok_ready, stk_push, stk_pop, stk_data_in
  );
  modport slave (
    input  tok_valid, tok_is_op, tok_data, stk_data_out, stk_full, stk_empty,
    output tok_ready, stk_push, stk_pop, stk_data_in
  );
endinterface

// File: rtl/rpn_engine.sv
// rpn_engine: RPN token evaluator driving an external stack via push/pop strobes.
module rpn_engine #(
  parameter int BANDWIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  rpn_if.slave                 bus,
  input  logic                 err_clr,
  output logic [BANDWIDTH-1:0] top,
  output logic                 top_valid,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_opcode
);
  typedef enum logic [2:0] {IDLE, PUSH, POP_B, LATCH_B, POP_A, LATCH_A, EXEC} state_t;
  state_t state, nxt;
  logic [BANDWIDTH-1:0] val, a, b, res;
  logic [2:0] op;
  logic accept, popping, ovf_ev, opc_ev, udf_ev;
  assign bus.tok_ready   = rstn && state == IDLE;
  assign accept          = bus.tok_valid && bus.tok_ready;
  assign popping         = state == POP_B || state == POP_A;
  assign ovf_ev          = accept && !bus.tok_is_op && bus.stk_full;
  assign opc_ev          = accept && bus.tok_is_op && bus.tok_data[2:1] == 2'b11;
  assign udf_ev          = popping && bus.stk_empty;
  assign bus.stk_pop     = popping && !bus.stk_empty;
  assign bus.stk_push    = state == PUSH;
  assign bus.stk_data_in = val;
  always_comb begin
    res = op == 3'd0 ? a + b :
          op == 3'd1 ? a - b :
          op == 3'd2 ? a * b :
          op == 3'd3 ? a & b :
          op == 3'd4 ? a | b : a ^ b;
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = bus.tok_is_op ? (opc_ev ? IDLE : POP_B) : (ovf_ev ? IDLE : PUSH);
      PUSH:    nxt = IDLE;
      POP_B:   nxt = bus.stk_empty ? IDLE : LATCH_B;
      LATCH_B: nxt = POP_A;
      POP_A:   nxt = bus.stk_empty ? IDLE : LATCH_A;
      LATCH_A: nxt = EXEC;
      EXEC:    nxt = PUSH;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end
  // An error event wins over a simultaneous clear so it is never lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val           <= '0;
      a             <= '0;
      b             <= '0;
      op            <= '0;
      top           <= '0;
      top_valid     <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_opcode    <= 1'b0;
    end else begin
      if (accept && !bus.tok_is_op && !bus.stk_full) val <= bus.tok_data;
      if (accept && bus.tok_is_op) op <= bus.tok_data[2:0];
      if (state == LATCH_B) b <= bus.stk_data_out;
      if (state == LATCH_A) a <= bus.stk_data_out;
      if (state == EXEC) val <= res;
      if (bus.stk_push) begin
        top       <= val;
        top_valid <= 1'b1;
      end
      err_overflow  <= ovf_ev || (err_overflow && !err_clr);
      err_underflow <= udf_ev || (err_underflow && !err_clr);
      err_opcode    <= opc_ev || (err_opcode && !err_clr);
    end
  end
endmodule

// File: tb/tb_rpn_engine.sv
// tb_rpn_engine: directed bench with a stack model and a push-data scoreboard.
module tb_rpn_engine;
  localparam int BW = 4;
  localparam int DEPTH = 8;
  logic clk = 0, rstn = 0, err_clr = 0;
  logic [BW-1:0] top;
  logic top_valid, err_overflow, err_underflow, err_opcode;
  rpn_if #(.BANDWIDTH(BW)) bus ();
  rpn_engine #(.BANDWIDTH(BW)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .err_clr(err_clr), .top(top),
    .top_valid(top_valid), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_opcode(err_opcode)
  );
  always #5 clk = ~clk;
  logic [BW-1:0] mem [DEPTH];
  int cnt = 0;
  logic force_full = 0, stk_clr = 0;
  assign bus.stk_full  = force_full || cnt == DEPTH;
  assign bus.stk_empty = cnt == 0;
  always @(posedge clk) begin
    if (stk_clr) cnt <= 0;
    else if (bus.stk_push && cnt < DEPTH) begin
      mem[cnt] <= bus.stk_data_in;
      cnt <= cnt + 1;
    end else if (bus.stk_pop && cnt > 0) begin
      bus.stk_data_out <= mem[cnt-1];
      cnt <= cnt - 1;
    end
  end
  int passed = 0, total = 0;
  logic [BW-1:0] exp_q[$], mstk[$];
  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask
  always @(negedge clk) begin
    if (rstn && bus.stk_push) begin
      check("push_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("push_data", bus.stk_data_in, exp_q.pop_front());
    end
    if (bus.stk_push || bus.stk_pop) check("no_overlap", bus.stk_push && bus.stk_pop, 0);
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send(bit is_op, logic [BW-1:0] d);
    int n = 0;
    while (!bus.tok_ready && n < 20) begin
      step;
      n++;
    end
    check("ready_wait", bus.tok_ready, 1);
    bus.tok_valid = 1;
    bus.tok_is_op = is_op;
    bus.tok_data  = d;
    step;
    bus.tok_valid = 0;
  endtask
  task automatic operand(logic [BW-1:0] v);
    mstk.push_back(v);
    exp_q.push_back(v);
    send(0, v);
    check("operand_push", bus.stk_push, 1);
    check("operand_data", bus.stk_data_in, v);
    step;
    check("operand_ready", bus.tok_ready, 1);
    check("operand_top", top, v);
    check("operand_top_valid", top_valid, 1);
  endtask
  function automatic logic [BW-1:0] alu(int op, logic [BW-1:0] x, logic [BW-1:0] y);
    int r;
    case (op)
      0: r = x + y;
      1: r = x - y;
      2: r = x * y;
      3: r = x & y;
      4: r = x | y;
      default: r = x ^ y;
    endcase
    return r[BW-1:0];
  endfunction
  task automatic oper(int op);
    logic [BW-1:0] a, b, r;
    b = mstk.pop_back();
    a = mstk.pop_back();
    r = alu(op, a, b);
    mstk.push_back(r);
    exp_q.push_back(r);
    send(1, BW'(op));
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("op%0d_c%0d_pop", op, c), bus.stk_pop, (c == 1 || c == 3));
      check($sformatf("op%0d_c%0d_push", op, c), bus.stk_push, c == 6);
      check($sformatf("op%0d_c%0d_ready", op, c), bus.tok_ready, c == 7);
      if (c < 7) step;
    end
    check($sformatf("op%0d_top", op), top, r);
  endtask
  task automatic check_reset_outputs(string tag);
    check({tag, "_ready"}, bus.tok_ready, 0);
    check({tag, "_strobes"}, {bus.stk_push, bus.stk_pop}, 0);
    check({tag, "_data_in"}, bus.stk_data_in, 0);
    check({tag, "_top"}, {top, top_valid}, 0);
    check({tag, "_errs"}, {err_overflow, err_underflow, err_opcode}, 0);
  endtask
  initial begin
    bus.tok_valid = 0;
    bus.tok_is_op = 0;
    bus.tok_data  = 0;
    repeat (2) step;
    check_reset_outputs("reset");
    rstn = 1;
    #1;
    check("ready_after_reset", bus.tok_ready, 1);
    operand(3); operand(4); oper(0);
    check("add_top_is_7", top, 7);
    check("no_errors", {err_overflow, err_underflow, err_opcode}, 0);
    operand(2); operand(5); oper(1);
    check("sub_top_is_13", top, 13);
    operand(6); operand(3); oper(2);
    check("mul_top_is_2", top, 2);
    oper(5);
    oper(4);
    operand(12); operand(10); oper(3);
    force_full = 1;
    send(0, 9);
    check("ovf_no_push", bus.stk_push, 0);
    check("ovf_flag", err_overflow, 1);
    check("ovf_ready", bus.tok_ready, 1);
    force_full = 0;
    step;
    check("ovf_sticky", err_overflow, 1);
    err_clr = 1; step; err_clr = 0;
    check("ovf_cleared", err_overflow, 0);
    send(1, 7);
    check("opc_no_strobes", {bus.stk_push, bus.stk_pop}, 0);
    check("opc_flag", err_opcode, 1);
    check("opc_ready", bus.tok_ready, 1);
    err_clr = 1; step; err_clr = 0;
    check("clr_all_flags", {err_overflow, err_underflow, err_opcode}, 0);
    err_clr = 1;
    send(1, 6);
    err_clr = 0;
    check("opc_with_clr_stays_set", err_opcode, 1);
    err_clr = 1; step; err_clr = 0;
    check("opc_cleared", err_opcode, 0);
    stk_clr = 1; step; stk_clr = 0;
    mstk.delete();
    operand(5);
    send(1, 0);
    check("udf_c1_pop", bus.stk_pop, 1);
    step;
    check("udf_c2_pop", bus.stk_pop, 0);
    step;
    check("udf_c3_strobes", {bus.stk_push, bus.stk_pop}, 0);
    step;
    check("udf_c4_ready", bus.tok_ready, 1);
    check("udf_c4_flag", err_underflow, 1);
    check("udf_c4_no_push", bus.stk_push, 0);
    mstk.delete();
    err_clr = 1; step; err_clr = 0;
    check("udf_cleared", err_underflow, 0);
    stk_clr = 1; step; stk_clr = 0;
    operand(1); operand(2);
    send(1, 0);
    check("rst_c1_pop", bus.stk_pop, 1);
    step;
    rstn = 0;
    #1;
    check_reset_outputs("midop_reset");
    step; step;
    check_reset_outputs("midop_held");
    rstn = 1;
    #1;
    check("ready_after_midop", bus.tok_ready, 1);
    mstk.delete();
    operand(1);
    step; step;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rpn_engine.md
RPN_ENGINE -- requirements
Module: rpn_engine

Interface
REQ-001 Parameter BANDWIDTH, default 4, SHALL set the operand, result and stack data width in bits; legal values are 3 or more.
REQ-002 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-003 rstn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 tok_valid  input  1  SHALL mean a token is offered.
REQ-005 tok_is_op  input  1  SHALL mean the token is an operator (1) or an operand (0).
REQ-006 tok_data  input  BANDWIDTH  SHALL carry the operand value, or the opcode in bits [2:0].
REQ-007 tok_ready  output  1  SHALL mean the engine accepts a token this cycle.
REQ-008 err_clr  input  1  SHALL synchronously clear all sticky error flags.
REQ-009 stk_push, stk_pop  output  1 each  SHALL be the push and pop strobes to the downstream stack.
REQ-010 stk_data_in  output  BANDWIDTH  SHALL carry the value to push.
REQ-011 stk_data_out  input  BANDWIDTH  SHALL carry the popped value, registered by the stack, valid the cycle after stk_pop.
REQ-012 stk_full, stk_empty  input  1 each  SHALL carry the stack status flags.
REQ-013 top, top_valid  output  BANDWIDTH/1  SHALL hold the last value pushed and whether any push has occurred since reset.
REQ-014 err_overflow, err_underflow, err_opcode  output  1 each  SHALL be the sticky error flags.

Function
REQ-015 FSM states SHALL be IDLE, PUSH, POP_B, LATCH_B, POP_A, LATCH_A, EXEC.
REQ-016 tok_ready SHALL be 1 only in IDLE, and a token SHALL be accepted on tok_valid && tok_ready.
REQ-017 Accepted operand with stk_full=0: SHALL register the value and go to PUSH; PUSH asserts stk_push=1 and stk_data_in=value for exactly one cycle, then returns to IDLE.
REQ-018 Accepted operand with stk_full=1: SHALL set err_overflow, drop the token and stay in IDLE.
REQ-019 Accepted operator with a legal opcode: SHALL go to POP_B.
REQ-020 Accepted operator with an illegal opcode: SHALL set err_opcode, take no stack action and stay in IDLE.
REQ-021 POP_B: if stk_empty=0, SHALL assert stk_pop for one cycle and go to LATCH_B; if stk_empty=1, SHALL set err_underflow and return to IDLE.
REQ-022 LATCH_B SHALL capture b=stk_data_out and go to POP_A.
REQ-023 POP_A SHALL apply the same rule as POP_B; on underflow the popped b SHALL be discarded.
REQ-024 LATCH_A SHALL capture a=stk_data_out and go to EXEC.
REQ-025 EXEC SHALL register r=f(a,b) and go to PUSH with stk_data_in=r.
REQ-026 Opcodes SHALL be: 0 ADD a+b, 1 SUB a-b, 2 MUL low BANDWIDTH bits of a*b, 3 AND, 4 OR, 5 XOR; 6 and 7 are illegal.
REQ-027 All arithmetic SHALL be modulo 2^BANDWIDTH, with no carry or borrow output.
REQ-028 Operator latency SHALL be: accept at cycle 0, stk_pop at cycles 1 and 3, stk_push at cycle 6, tok_ready=1 again at cycle 7.
REQ-029 Operand latency SHALL be: accept at cycle 0, stk_push at cycle 1, tok_ready=1 at cycle 2.
REQ-030 stk_push and stk_pop SHALL never be asserted in the same cycle.
REQ-031 Each strobe SHALL be a single-cycle pulse.
REQ-032 On every stk_push, top SHALL take stk_data_in in the following cycle and top_valid SHALL become 1.
REQ-033 Error flags SHALL be sticky until err_clr or reset.
REQ-034 An error event coinciding with err_clr SHALL leave its flag set.
REQ-035 Error flags SHALL NOT block further token processing.

Reset
REQ-036 While rstn=0, state SHALL be IDLE; stk_push, stk_pop, stk_data_in, top, top_valid and all error flags SHALL be 0; and tok_ready SHALL be 0.
REQ-037 Reset asserted mid-operator SHALL abandon the operation with no further stack strobes.
REQ-038 tok_ready SHALL be 1 in the first cycle after rstn rises.

Verification
REQ-039 Operand 3, operand 4, ADD with BANDWIDTH=4 -> pushes of 3, 4, then 7; top=7; no errors.
REQ-040 Operand 2, operand 5, SUB -> pushed result 13 (2-5 mod 16); operand 6, operand 3, MUL -> pushed result 2 (18 mod 16).
REQ-041 stk_full=1 with operand 9 offered -> no stk_push; err_overflow=1; tok_ready stays 1.
REQ-042 Stack holding one entry, then ADD -> one stk_pop; at POP_A stk_empty=1 -> err_underflow=1; no push; back in IDLE at cycle 4.
REQ-043 Opcode 7 -> err_opcode=1, no strobes; err_clr pulse -> all flags 0 next cycle.
REQ-044 rstn low during LATCH_B -> all outputs 0 immediately; after release, operand 1 -> stk_push with data 1 at cycle 1.
